// File: rtl/pc_sequencer_if.sv
// Decode/control <-> PC sequencer bus: op request in, PC and return-stack status out.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                  pc_update_en_in;
  logic [2:0]            pc_op_in;
  logic [ADDR_WIDTH-1:0] jump_addr_in;
  logic [ADDR_WIDTH-1:0] offset_in;
  logic [ADDR_WIDTH-1:0] program_counter_out;
  logic [ADDR_WIDTH-1:0] return_addr_out;
  logic [DEPTH_W-1:0]    stack_depth_out;
  logic                  stack_empty_out;
  logic                  stack_full_out;
  logic                  overflow_err_out;
  logic                  underflow_err_out;

  modport master (
    output pc_update_en_in, pc_op_in, jump_addr_in, offset_in,
    input  program_counter_out, return_addr_out, stack_depth_out,
           stack_empty_out, stack_full_out, overflow_err_out, underflow_err_out
  );

  modport slave (
    input  pc_update_en_in, pc_op_in, jump_addr_in, offset_in,
    output program_counter_out, return_addr_out, stack_depth_out,
           stack_empty_out, stack_full_out, overflow_err_out, underflow_err_out
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with INC/JUMP/BRANCH/CALL/RET and a hardware return-address stack.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           ALIGN_BITS   = 1,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic           clk_in,
  input logic           reset_n_in,
  pc_sequencer_if.slave bus
);
  localparam int unsigned PC_W    = ADDR_WIDTH - ALIGN_BITS;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_W   = STACK_DEPTH * PC_W;

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  logic [PC_W-1:0]       pc_q, pc_d;
  logic [STK_W-1:0]      stack_q, stack_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic [PC_W-1:0]       pc_inc;
  logic [PC_W-1:0]       jump_tgt;
  logic [PC_W-1:0]       stack_top;
  logic [ADDR_WIDTH-1:0] pc_full;
  logic [ADDR_WIDTH-1:0] branch_sum;
  logic                  is_full;
  logic                  is_empty;

  // Entry 0 of the packed stack is the top; pushes shift older entries toward the far end.
  assign stack_top  = stack_q[PC_W-1:0];
  assign pc_inc     = pc_q + PC_W'(1);
  assign jump_tgt   = PC_W'(bus.jump_addr_in >> ALIGN_BITS);
  assign pc_full    = ADDR_WIDTH'(pc_q) << ALIGN_BITS;
  assign branch_sum = pc_full + bus.offset_in;
  assign is_full    = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign is_empty   = (depth_q == '0);

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      pc_q    <= PC_W'(RESET_VECTOR >> ALIGN_BITS);
      stack_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.pc_update_en_in) begin
      case (op_e'(bus.pc_op_in))
        OP_INC:    pc_d = pc_inc;
        OP_JUMP:   pc_d = jump_tgt;
        OP_BRANCH: pc_d = PC_W'(branch_sum >> ALIGN_BITS);
        OP_CALL: begin
          // A push onto a full stack naturally shifts the oldest entry out of the far end.
          stack_d = {stack_q[STK_W-PC_W-1:0], pc_inc};
          pc_d    = jump_tgt;
          if (is_full) ovf_d = 1'b1;
          else         depth_d = depth_q + DEPTH_W'(1);
        end
        OP_RET: begin
          if (is_empty) begin
            pc_d  = pc_inc;
            udf_d = 1'b1;
          end else begin
            pc_d    = stack_top;
            stack_d = {{PC_W{1'b0}}, stack_q[STK_W-1:PC_W]};
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.program_counter_out = pc_full;
  assign bus.return_addr_out     = is_empty ? '0 : (ADDR_WIDTH'(stack_top) << ALIGN_BITS);
  assign bus.stack_depth_out     = depth_q;
  assign bus.stack_empty_out     = is_empty;
  assign bus.stack_full_out      = is_full;
  assign bus.overflow_err_out    = ovf_q;
  assign bus.underflow_err_out   = udf_q;
endmodule
